// File: rtl/bpsk_frame_loader.sv
// Builds a 150-byte BPSK frame (preamble, sync, length, payload, pad, CRC-16) in RAM
// from a byte stream, then holds send_signal until the reader reports the frame was sent.
module bpsk_frame_loader #(
    parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
    parameter logic [15:0] SYNC_WORD     = 16'h1ACF,
    parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wr_data,
    input  logic        frame_sent,
    output logic        send_signal,
    output logic        err_oversize,
    output logic [15:0] frame_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        PAD     = 3'd3,
        LEN     = 3'd4,
        CRC_HI  = 3'd5,
        CRC_LO  = 3'd6,
        ARMED   = 3'd7
    } state_t;

    localparam logic [7:0] LAST_HDR_ADDR     = 8'd5;
    localparam logic [7:0] LEN_ADDR          = 8'd6;
    localparam logic [7:0] FIRST_PAYLOAD     = 8'd7;
    localparam logic [7:0] LAST_PAYLOAD_ADDR = 8'd147;
    localparam logic [7:0] CRC_HI_ADDR       = 8'd148;
    localparam logic [7:0] CRC_LO_ADDR       = 8'd149;
    localparam logic [7:0] MAX_PAYLOAD       = 8'd141;

    state_t      state;
    logic [7:0]  idx;
    logic [7:0]  count;
    logic [15:0] crc;

    // CRC-16-CCITT, polynomial 0x1021, one byte MSB-first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [7:0] a);
        case (a)
            8'd4:    return SYNC_WORD[15:8];
            8'd5:    return SYNC_WORD[7:0];
            default: return PREAMBLE_BYTE;
        endcase
    endfunction

    // Input stream: a byte moves on a rising edge where s_valid and s_ready are both 1;
    // s_ready is high exactly while the FSM is in PAYLOAD. RAM port outputs are registered,
    // so each write appears on the port the cycle after the state that issued it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 8'd0;
            count        <= 8'd0;
            crc          <= 16'hFFFF;
            s_ready      <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= 8'd0;
            ram_wr_data  <= 8'd0;
            send_signal  <= 1'b0;
            err_oversize <= 1'b0;
            frame_count  <= 16'd0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        state <= HDR;
                        idx   <= 8'd0;
                        count <= 8'd0;
                        crc   <= 16'hFFFF;
                    end
                end
                HDR: begin
                    ram_en      <= 1'b1;
                    ram_we      <= 1'b1;
                    ram_addr    <= idx;
                    ram_wr_data <= hdr_byte(idx);
                    if (idx == LAST_HDR_ADDR) begin
                        state   <= PAYLOAD;
                        s_ready <= 1'b1;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                PAYLOAD: begin
                    if (s_valid && s_ready) begin
                        if (count < MAX_PAYLOAD) begin
                            ram_en      <= 1'b1;
                            ram_we      <= 1'b1;
                            ram_addr    <= FIRST_PAYLOAD + count;
                            ram_wr_data <= s_data;
                            crc         <= crc_step(crc, s_data);
                            count       <= count + 8'd1;
                            if (count == MAX_PAYLOAD - 8'd1) begin
                                if (s_last) begin
                                    state   <= LEN;
                                    s_ready <= 1'b0;
                                end else begin
                                    err_oversize <= 1'b1;
                                end
                            end else if (s_last) begin
                                state   <= PAD;
                                s_ready <= 1'b0;
                                idx     <= FIRST_PAYLOAD + count + 8'd1;
                            end
                        end else if (s_last) begin
                            // Payload full: bytes past the limit are dropped until s_last.
                            state   <= LEN;
                            s_ready <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    ram_en      <= 1'b1;
                    ram_we      <= 1'b1;
                    ram_addr    <= idx;
                    ram_wr_data <= PAD_BYTE;
                    crc         <= crc_step(crc, PAD_BYTE);
                    if (idx == LAST_PAYLOAD_ADDR) state <= LEN;
                    else                          idx   <= idx + 8'd1;
                end
                LEN: begin
                    ram_en      <= 1'b1;
                    ram_we      <= 1'b1;
                    ram_addr    <= LEN_ADDR;
                    ram_wr_data <= count;
                    state       <= CRC_HI;
                end
                CRC_HI: begin
                    ram_en      <= 1'b1;
                    ram_we      <= 1'b1;
                    ram_addr    <= CRC_HI_ADDR;
                    ram_wr_data <= crc[15:8];
                    state       <= CRC_LO;
                end
                CRC_LO: begin
                    ram_en      <= 1'b1;
                    ram_we      <= 1'b1;
                    ram_addr    <= CRC_LO_ADDR;
                    ram_wr_data <= crc[7:0];
                    frame_count <= frame_count + 16'd1;
                    send_signal <= 1'b1;
                    state       <= ARMED;
                end
                ARMED: begin
                    if (frame_sent) begin
                        send_signal <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bpsk_frame_loader.sv
// Directed bench for bpsk_frame_loader: table of frame scenarios plus hand-written
// sequences for frame_sent timing, reset abort and back-to-back frames.
module tb_bpsk_frame_loader;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_PAD     = 3'd3;
    localparam logic [2:0] ST_ARMED   = 3'd7;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wr_data;
    logic        frame_sent;
    logic        send_signal;
    logic        err_oversize;
    logic [15:0] frame_count;
    logic [2:0]  dbg_state;

    bpsk_frame_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wr_data  (ram_wr_data),
        .frame_sent   (frame_sent),
        .send_signal  (send_signal),
        .err_oversize (err_oversize),
        .frame_count  (frame_count),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] seed;
        logic [7:0] exp_n;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          wr_count = 0;
    int          seq_err = 0;
    logic [15:0] bad_got;
    logic [15:0] bad_exp;
    logic [15:0] mon_e;
    bit          sb_on = 1'b1;
    logic [7:0]  mem [0:149];
    int          exp_frames = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every RAM write is matched in order against the expected queue.
    always @(negedge clk) begin
        if (ram_en && ram_we) begin
            wr_count++;
            if (ram_addr <= 8'd149) mem[ram_addr] = ram_wr_data;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    if (seq_err == 0) begin
                        bad_got = {ram_addr, ram_wr_data};
                        bad_exp = 16'hFFFF;
                    end
                    seq_err++;
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e !== {ram_addr, ram_wr_data}) begin
                        if (seq_err == 0) begin
                            bad_got = {ram_addr, ram_wr_data};
                            bad_exp = mon_e;
                        end
                        seq_err++;
                    end
                end
            end
        end
    end

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [7:0] pl_byte(input logic [7:0] seed, input int i);
        if (seed == 8'h00) return 8'h31 + 8'(i);
        return seed + 8'(i * 29);
    endfunction

    task automatic start_frame(input int len, input logic [7:0] seed, output logic [15:0] crc_out);
        int         n;
        logic [15:0] c;
        logic [7:0] b;
        exp_q.delete();
        wr_count = 0;
        seq_err  = 0;
        n = (len > 141) ? 141 : len;
        for (int a = 0; a < 4; a++) exp_q.push_back({8'(a), 8'h55});
        exp_q.push_back({8'd4, 8'h1A});
        exp_q.push_back({8'd5, 8'hCF});
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = pl_byte(seed, i);
            exp_q.push_back({8'(7 + i), b});
            c = crc_model(c, b);
        end
        for (int a = 7 + n; a <= 147; a++) begin
            exp_q.push_back({8'(a), 8'h00});
            c = crc_model(c, 8'h00);
        end
        exp_q.push_back({8'd6, 8'(n)});
        exp_q.push_back({8'd148, c[15:8]});
        exp_q.push_back({8'd149, c[7:0]});
        crc_out = c;
    endtask

    // Called at a negedge; returns at the negedge after the final byte's handshake edge.
    task automatic send_frame(input string tag, input int len, input logic [7:0] seed,
                              input int fs_at, input bit hold, input logic [7:0] next_first);
        int i;
        int guard;
        bit ready_now;
        i = 0;
        guard = 0;
        while (i < len && guard < 2000) begin
            s_valid    = 1'b1;
            s_data     = pl_byte(seed, i);
            s_last     = (i == len - 1);
            frame_sent = (i == fs_at);
            ready_now  = s_ready;
            @(posedge clk);
            @(negedge clk);
            frame_sent = 1'b0;
            if (ready_now) begin
                if (i == fs_at) begin
                    check({tag, "_fs_ignored_state"}, dbg_state, ST_PAYLOAD);
                    check({tag, "_fs_ignored_send"}, send_signal, 0);
                end
                i++;
            end
            guard++;
        end
        check({tag, "_bytes_sent"}, i, len);
        s_last = 1'b0;
        if (hold) s_data = next_first;
        else      s_valid = 1'b0;
    endtask

    task automatic wait_armed(output int k);
        k = 0;
        while (send_signal !== 1'b1 && k < 400) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic frame_checks(input string tag, input logic [7:0] exp_n, input logic exp_err,
                                input logic [15:0] exp_crc, input int lat, input int exp_lat);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_write_seq_errors"}, seq_err, 0);
        if (seq_err != 0) $display("  %s first bad write got=%h expected=%h", tag, bad_got, bad_exp);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_write_count"}, wr_count, 150);
        check({tag, "_len_byte"}, mem[6], exp_n);
        check({tag, "_crc"}, {mem[148], mem[149]}, exp_crc);
        check({tag, "_err_oversize"}, err_oversize, exp_err);
        check({tag, "_frame_count"}, frame_count, exp_frames);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_armed_state"}, dbg_state, ST_ARMED);
        check({tag, "_send_signal"}, send_signal, 1);
    endtask

    task automatic release_frame(input string tag);
        frame_sent = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_sent = 1'b0;
        check({tag, "_send_fall"}, send_signal, 0);
        check({tag, "_idle"}, dbg_state, ST_IDLE);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_ram_en_we"}, {ram_en, ram_we}, 0);
        check({tag, "_ram_addr_data"}, {ram_addr, ram_wr_data}, 0);
        check({tag, "_send_signal"}, send_signal, 0);
        check({tag, "_err_oversize"}, err_oversize, 0);
        check({tag, "_frame_count"}, frame_count, 0);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [15:0] crc_exp;
        int          lat;
        bit          armed_bad;

        vecs[0] = '{len: 9,   seed: 8'h00, exp_n: 8'h09, exp_err: 1'b0, exp_lat: 135};
        vecs[1] = '{len: 1,   seed: 8'h5A, exp_n: 8'h01, exp_err: 1'b0, exp_lat: 143};
        vecs[2] = '{len: 140, seed: 8'hC3, exp_n: 8'h8C, exp_err: 1'b0, exp_lat: 4};
        vecs[3] = '{len: 141, seed: 8'h17, exp_n: 8'h8D, exp_err: 1'b0, exp_lat: 3};
        vecs[4] = '{len: 145, seed: 8'h6E, exp_n: 8'h8D, exp_err: 1'b1, exp_lat: 3};

        rst        = 1'b1;
        s_data     = 8'h00;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        frame_sent = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            start_frame(vecs[v].len, vecs[v].seed, crc_exp);
            send_frame($sformatf("v%0d", v), vecs[v].len, vecs[v].seed, -1, 1'b0, 8'h00);
            wait_armed(lat);
            exp_frames++;
            frame_checks($sformatf("v%0d", v), vecs[v].exp_n, vecs[v].exp_err, crc_exp,
                         lat, vecs[v].exp_lat);
            release_frame($sformatf("v%0d", v));
        end

        // frame_sent during PAYLOAD is ignored; in ARMED it releases the frame.
        start_frame(6, 8'h99, crc_exp);
        send_frame("fs", 6, 8'h99, 2, 1'b0, 8'h00);
        wait_armed(lat);
        exp_frames++;
        frame_checks("fs", 8'h06, 1'b1, crc_exp, lat, 138);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("fs_armed_hold", {dbg_state, send_signal}, {ST_ARMED, 1'b1});
        release_frame("fs");

        // Reset while padding with s_valid held high aborts the frame.
        sb_on = 1'b0;
        start_frame(3, 8'h21, crc_exp);
        send_frame("rpad", 3, 8'h21, -1, 1'b1, pl_byte(8'h42, 0));
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rpad_in_pad", dbg_state, ST_PAD);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_checks("rpad_reset");
        exp_frames = 0;
        start_frame(5, 8'h42, crc_exp);
        sb_on = 1'b1;
        rst = 1'b0;
        send_frame("rnew", 5, 8'h42, -1, 1'b0, 8'h00);
        wait_armed(lat);
        exp_frames++;
        frame_checks("rnew", 8'h05, 1'b0, crc_exp, lat, 139);
        release_frame("rnew");

        // Back-to-back frames with s_valid held high, starting from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        start_frame(4, 8'hA7, crc_exp);
        send_frame("b2b1", 4, 8'hA7, -1, 1'b1, pl_byte(8'h3C, 0));
        wait_armed(lat);
        exp_frames++;
        frame_checks("b2b1", 8'h04, 1'b0, crc_exp, lat, 140);
        armed_bad = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (s_ready !== 1'b0 || dbg_state !== ST_ARMED) armed_bad = 1'b1;
        end
        check("b2b_waits_in_armed", armed_bad, 0);
        start_frame(3, 8'h3C, crc_exp);
        release_frame("b2b1");
        send_frame("b2b2", 3, 8'h3C, -1, 1'b0, 8'h00);
        wait_armed(lat);
        exp_frames++;
        frame_checks("b2b2", 8'h03, 1'b0, crc_exp, lat, 141);
        release_frame("b2b2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
